// File: rtl/test_cpu_debug_pkg.sv
// Shared definitions for the virtual-JTAG debug host: scan-state encoding
// and default register widths.
package test_cpu_debug_pkg;

   localparam int IR_W_DEF = 2;
   localparam int DR_W_DEF = 38;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_UIR  = 3'd1,
      ST_CDR  = 3'd2,
      ST_SDR  = 3'd3,
      ST_UDR  = 3'd4,
      ST_RTI  = 3'd5,
      ST_DONE = 3'd6
   } scan_state_e;

   // States during which TCK toggles and a strobe is asserted.
   function automatic logic is_scan_state(input scan_state_e s);
      return (s == ST_UIR) || (s == ST_CDR) || (s == ST_SDR) ||
             (s == ST_UDR) || (s == ST_RTI);
   endfunction

endpackage

// File: rtl/test_cpu_debug_host_tckgen.sv
// TCK generator: while enabled, each tick is TCK_HALF clks low then TCK_HALF
// clks high; pulses mark tick start, the rising phase and the last clk of a tick.
module test_cpu_debug_host_tckgen #(
   parameter int TCK_HALF = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_en,
   output logic o_tck,
   output logic o_tick_start,
   output logic o_rise,
   output logic o_tick_end
);

   localparam int PW = (2 * TCK_HALF > 1) ? $clog2(2 * TCK_HALF) : 1;
   localparam logic [PW-1:0] PH_HALF = PW'(TCK_HALF);
   localparam logic [PW-1:0] PH_LAST = PW'(2 * TCK_HALF - 1);

   logic [PW-1:0] r_phase;

   // Phase restarts at 0 whenever the generator is idle, so the first
   // enabled clk is always the start of a fresh tick.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_phase <= '0;
      end else if (!i_en || (r_phase == PH_LAST)) begin
         r_phase <= '0;
      end else begin
         r_phase <= r_phase + 1'b1;
      end
   end

   assign o_tck        = i_en && (r_phase >= PH_HALF);
   assign o_tick_start = i_en && (r_phase == '0);
   assign o_rise       = i_en && (r_phase == PH_HALF);
   assign o_tick_end   = i_en && (r_phase == PH_LAST);

endmodule

// File: rtl/test_cpu_debug_host_scan.sv
// Debug host that runs one virtual-JTAG IR/DR scan per accepted command and
// returns the bits captured from the slave.
module test_cpu_debug_host_scan
   import test_cpu_debug_pkg::*;
#(
   parameter int TCK_HALF  = 2,
   parameter int DR_W      = DR_W_DEF,
   parameter int IR_W      = IR_W_DEF,
   parameter int RTI_TICKS = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [IR_W-1:0] cmd_ir,
   input  logic [DR_W-1:0] cmd_dr,
   output logic            rsp_valid,
   output logic [DR_W-1:0] rsp_data,
   output logic            vji_tck,
   output logic            vji_tdi,
   input  logic            vji_tdo,
   output logic [IR_W-1:0] vji_ir_in,
   output logic            vji_uir,
   output logic            vji_cdr,
   output logic            vji_sdr,
   output logic            vji_udr,
   output logic            vji_rti
);

   localparam int MAX_DWELL = (DR_W > RTI_TICKS) ? DR_W : RTI_TICKS;
   localparam int TW        = $clog2(MAX_DWELL + 1);
   localparam logic [TW-1:0] DWELL_ONE = TW'(1);
   localparam logic [TW-1:0] DWELL_SDR = TW'(DR_W);
   localparam logic [TW-1:0] DWELL_RTI = TW'(RTI_TICKS);

   scan_state_e     r_state;
   scan_state_e     w_state_next;
   scan_state_e     w_after;
   logic [TW-1:0]   r_tick;
   logic [TW-1:0]   w_tick_next;
   logic [TW-1:0]   w_dwell;
   logic [IR_W-1:0] r_ir;
   logic [DR_W-1:0] r_dr_shift;
   logic [DR_W-1:0] r_cap;
   logic [DR_W-1:0] r_rsp_data;
   logic            w_en;
   logic            w_tck;
   logic            w_tick_start;
   logic            w_rise;
   logic            w_tick_end;
   logic            w_accept;

   assign w_en     = is_scan_state(r_state);
   assign w_accept = (r_state == ST_IDLE) && cmd_valid;

   test_cpu_debug_host_tckgen #(
      .TCK_HALF (TCK_HALF)
   ) u_tckgen (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_en         (w_en),
      .o_tck        (w_tck),
      .o_tick_start (w_tick_start),
      .o_rise       (w_rise),
      .o_tick_end   (w_tick_end)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_tick  <= '0;
      end else begin
         r_state <= w_state_next;
         r_tick  <= w_tick_next;
      end
   end

   // r_tick counts ticks started in the current state; a state is left on
   // the last clk of its final tick so every move lands on a tick boundary.
   always_comb begin
      w_state_next = r_state;
      w_tick_next  = w_tick_start ? (r_tick + 1'b1) : r_tick;
      w_dwell      = DWELL_ONE;
      w_after      = ST_IDLE;
      case (r_state)
         ST_UIR: w_after = ST_CDR;
         ST_CDR: w_after = ST_SDR;
         ST_SDR: begin
            w_dwell = DWELL_SDR;
            w_after = ST_UDR;
         end
         ST_UDR: w_after = ST_RTI;
         ST_RTI: begin
            w_dwell = DWELL_RTI;
            w_after = ST_DONE;
         end
         default: w_after = ST_IDLE;
      endcase
      case (r_state)
         ST_IDLE: begin
            if (cmd_valid) begin
               w_state_next = ST_UIR;
               w_tick_next  = '0;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
            w_tick_next  = '0;
         end
         default: begin
            if (w_tick_end && (r_tick == w_dwell)) begin
               w_state_next = w_after;
               w_tick_next  = '0;
            end
         end
      endcase
   end

   // Outgoing data shifts right once per SDR tick; captured bits enter at the
   // MSB so the first bit sampled ends up in bit 0 after DR_W ticks.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_ir       <= '0;
         r_dr_shift <= '0;
         r_cap      <= '0;
         r_rsp_data <= '0;
      end else begin
         if (w_accept) begin
            r_ir       <= cmd_ir;
            r_dr_shift <= cmd_dr;
            r_cap      <= '0;
         end else if (r_state == ST_SDR) begin
            if (w_rise) begin
               r_cap <= (r_cap >> 1) | (DR_W'(vji_tdo) << (DR_W - 1));
            end
            if (w_tick_end) begin
               r_dr_shift <= r_dr_shift >> 1;
            end
         end
         if ((r_state == ST_RTI) && (w_state_next == ST_DONE)) begin
            r_rsp_data <= r_cap;
         end
      end
   end

   always_comb begin
      cmd_ready = (r_state == ST_IDLE);
      rsp_valid = (r_state == ST_DONE);
      rsp_data  = r_rsp_data;
      vji_tck   = w_tck;
      vji_tdi   = (r_state == ST_SDR) && r_dr_shift[0];
      vji_ir_in = r_ir;
      vji_uir   = (r_state == ST_UIR);
      vji_cdr   = (r_state == ST_CDR);
      vji_sdr   = (r_state == ST_SDR);
      vji_udr   = (r_state == ST_UDR);
      vji_rti   = (r_state == ST_RTI);
   end

endmodule

// File: doc/test_cpu_debug_host_scan.md
TEST_CPU_DEBUG_HOST_SCAN -- requirements
Module: test_cpu_debug_host_scan

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  TCK_HALF, 2, clk cycles per TCK phase (≥1); one tick = 2*TCK_HALF clk.
  DR_W, 38, data-register scan length in bits.
  IR_W, 2, virtual IR width.
  RTI_TICKS, 2, ticks spent in run-test-idle after update (≥1).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk  in  1  sole clock.
  reset_n  in  1  synchronous, active-low reset.
  cmd_valid  in  1  command request.
  cmd_ready  out  1  command accepted when high with cmd_valid.
  cmd_ir  in  IR_W  virtual IR value for the scan.
  cmd_dr  in  DR_W  data shifted out, LSB first.
  rsp_valid  out  1  one-clk pulse: scan complete.
  rsp_data  out  DR_W  bits captured from vji_tdo, held until next rsp_valid.
  vji_tck  out  1  generated TCK.
  vji_tdi  out  1  serial data to debug slave.
  vji_tdo  in  1  serial data from debug slave.
  vji_ir_in  out  IR_W  virtual IR driven to slave.
  vji_uir / vji_cdr / vji_sdr / vji_udr / vji_rti  out  1 each  virtual state strobes.
REQ-003 SHALL use one clock; reset is synchronous and active-low.

Function
REQ-004 SHALL implement states IDLE, UIR, CDR, SDR, UDR, RTI, DONE.
REQ-005 SHALL assert cmd_ready only in IDLE; accept on the clk edge where cmd_valid&&cmd_ready, latch cmd_ir and cmd_dr, and enter UIR on the next cycle.
REQ-006 SHALL hold vji_tck=0 in IDLE and DONE; in all other states, each tick drives vji_tck=0 for TCK_HALF clks, then 1 for TCK_HALF clks.
REQ-007 SHALL dwell 1 tick in UIR, 1 in CDR, DR_W in SDR, 1 in UDR, and RTI_TICKS in RTI; transitions occur only at tick boundaries.
REQ-008 SHALL assert exactly one state strobe (uir/cdr/sdr/udr/rti) matching the current state for the whole of that state; all are 0 in IDLE/DONE.
REQ-009 SHALL drive vji_ir_in = latched cmd_ir from UIR entry until return to IDLE; it holds its last value in IDLE.
REQ-010 SHALL, in SDR tick k (0..DR_W-1), drive vji_tdi = latched cmd_dr[k] for the full tick, and otherwise hold vji_tdi=0.
REQ-011 SHALL sample vji_tdo on the first clk of each SDR tick's high phase and store it into capture bit k.
REQ-012 SHALL spend one cycle in DONE, asserting rsp_valid with rsp_data = the captured bits, then return to IDLE; cmd_ready=0 in DONE.
REQ-013 SHALL take (4+DR_W+RTI_TICKS-1)*2*TCK_HALF... specifically: acceptance at edge N gives rsp_valid high in cycle N+1+(3+DR_W+RTI_TICKS)*2*TCK_HALF (defaults: N+173).
REQ-014 SHALL ignore cmd_valid and cmd_* changes while not in IDLE; no queuing.
REQ-015 SHALL accept a new command in the cycle immediately after DONE (back-to-back scans with one idle cycle).

Reset
REQ-016 SHALL, when reset_n=0 at a clk edge, go to IDLE with the following values: cmd_ready=1 after release, rsp_valid=0, rsp_data=0, vji_tck=0, vji_tdi=0, vji_ir_in=0, all strobes 0, and tick counter 0.
REQ-017 SHALL abort any scan in progress on reset, with no rsp_valid for the aborted command.

Structure
REQ-018 SHALL place the state enum and the IR_W/DR_W defaults in shared package test_cpu_debug_pkg.
REQ-019 SHALL put TCK phase/tick generation in sub-module test_cpu_debug_host_tckgen, which outputs the tck level, a tick_start pulse, and a rise pulse.

Verification
REQ-020 Single scan: cmd_ir=2'b01, cmd_dr=38'h2A_5555_AAAA, vji_tdo looped to vji_tdi -> rsp_data=38'h2A_5555_AAAA, rsp_valid at N+173, vji_ir_in=01.
REQ-021 Capture: vji_tdo driven by a slave model that returns 38'h3F_0000_0001 LSB-first -> rsp_data=38'h3F_0000_0001.
REQ-022 Strobe timing: the bench counts ticks -> uir=1, cdr=1, sdr=38, udr=1, rti=2, with strobes one-hot and vji_tck low in IDLE.
REQ-023 Back-to-back: cmd_valid held high with two commands (ir=00, then 10) -> second accepted 1 cycle after first rsp_valid, and cmd_valid changes mid-scan are ignored.
REQ-024 Reset mid-SDR: reset_n=0 for one cycle at scan bit 20 -> all outputs at reset values next cycle, no rsp_valid, next command completes normally.
REQ-025 TCK_HALF=1, RTI_TICKS=1 build: loopback 38'h00_FFFF_0000 -> correct rsp_data, rsp_valid at N+1+84.
